// File: rtl/uart_cfg_ctrl.sv
// Command-frame controller: delimits 7-byte frames (SYNC, ADDR, D3..D0, CHK) from
// the uart_rx byte stream and commits validated payloads into the DDS control registers.
module uart_cfg_ctrl #(
  parameter int          F_CLK        = 12_000_000,
  parameter int          UART_BAUD    = 9600,
  parameter int          TIMEOUT_CLKS = (F_CLK / UART_BAUD) * 20,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        SER_CLK,
  input  logic        RST,
  input  logic        RX_DV,
  input  logic [7:0]  RX_BYTE,
  output logic [31:0] FREQ_WORD,
  output logic [15:0] PHASE_WORD,
  output logic [7:0]  AMPLITUDE,
  output logic        OUT_EN,
  output logic        CFG_UPDATE,
  output logic        FRAME_ERR,
  output logic [7:0]  ERR_COUNT
);

  typedef enum logic [2:0] {
    ST_HUNT, ST_ADDR, ST_DATA, ST_CHECK, ST_COMMIT
  } state_t;

  localparam logic [31:0] GAP_LIM = 32'(TIMEOUT_CLKS - 1);

  state_t      state, state_n;
  logic [31:0] gap;
  logic [31:0] payload;
  logic [7:0]  addr;
  logic [7:0]  chk;
  logic [1:0]  idx;
  logic        match;
  logic        tmo_q;

  logic gap_run, tmo, commit_ok, commit_err, err_evt;

  always_ff @(posedge SER_CLK or posedge RST) begin
    if (RST) state <= ST_HUNT;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    commit_ok  = 1'b0;
    commit_err = 1'b0;
    gap_run    = (state == ST_ADDR) || (state == ST_DATA) || (state == ST_CHECK);
    // A byte landing on the limit cycle wins over the timeout
    tmo        = gap_run && !RX_DV && (gap == GAP_LIM);
    case (state)
      ST_HUNT:   if (RX_DV && RX_BYTE == SYNC_BYTE) state_n = ST_ADDR;
      ST_ADDR:   if (RX_DV) state_n = ST_DATA;
      ST_DATA:   if (RX_DV && idx == 2'd3) state_n = ST_CHECK;
      ST_CHECK:  if (RX_DV) state_n = ST_COMMIT;
      ST_COMMIT: begin
        state_n = ST_HUNT;
        if (match && addr <= 8'h03) commit_ok  = 1'b1;
        else                        commit_err = 1'b1;
      end
      default:   state_n = ST_HUNT;
    endcase
    if (tmo) state_n = ST_HUNT;
  end

  // Timeout error is reported one cycle after the abort to HUNT
  assign err_evt = commit_err || tmo_q;

  always_ff @(posedge SER_CLK or posedge RST) begin
    if (RST) begin
      gap        <= '0;
      payload    <= '0;
      addr       <= '0;
      chk        <= '0;
      idx        <= '0;
      match      <= 1'b0;
      tmo_q      <= 1'b0;
      FREQ_WORD  <= '0;
      PHASE_WORD <= '0;
      AMPLITUDE  <= '0;
      OUT_EN     <= 1'b0;
      CFG_UPDATE <= 1'b0;
      FRAME_ERR  <= 1'b0;
      ERR_COUNT  <= '0;
    end else begin
      if (!gap_run || RX_DV || tmo) gap <= '0;
      else                          gap <= gap + 32'd1;

      tmo_q <= tmo;

      if (RX_DV) begin
        case (state)
          ST_ADDR: begin
            addr <= RX_BYTE;
            chk  <= RX_BYTE;
            idx  <= '0;
          end
          ST_DATA: begin
            payload <= {payload[23:0], RX_BYTE};
            chk     <= chk ^ RX_BYTE;
            idx     <= idx + 2'd1;
          end
          ST_CHECK: match <= (RX_BYTE == chk);
          default: ;
        endcase
      end

      if (commit_ok) begin
        case (addr[1:0])
          2'd0: FREQ_WORD  <= payload;
          2'd1: PHASE_WORD <= payload[15:0];
          2'd2: AMPLITUDE  <= payload[7:0];
          2'd3: OUT_EN     <= payload[0];
          default: ;
        endcase
      end

      CFG_UPDATE <= commit_ok;
      FRAME_ERR  <= err_evt;
      if (err_evt && ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Bench for uart_cfg_ctrl: directed frames from the test plan plus randomized frames
// checked against a frame-level reference model (register image + error count).
module tb_uart_cfg_ctrl;
  localparam int         TMO  = 40;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        SER_CLK = 1'b0;
  logic        RST;
  logic        RX_DV;
  logic [7:0]  RX_BYTE;
  logic [31:0] FREQ_WORD;
  logic [15:0] PHASE_WORD;
  logic [7:0]  AMPLITUDE;
  logic        OUT_EN;
  logic        CFG_UPDATE;
  logic        FRAME_ERR;
  logic [7:0]  ERR_COUNT;

  uart_cfg_ctrl #(.TIMEOUT_CLKS(TMO), .SYNC_BYTE(SYNC)) dut (
    .SER_CLK(SER_CLK), .RST(RST), .RX_DV(RX_DV), .RX_BYTE(RX_BYTE),
    .FREQ_WORD(FREQ_WORD), .PHASE_WORD(PHASE_WORD), .AMPLITUDE(AMPLITUDE),
    .OUT_EN(OUT_EN), .CFG_UPDATE(CFG_UPDATE), .FRAME_ERR(FRAME_ERR),
    .ERR_COUNT(ERR_COUNT)
  );

  always #5 SER_CLK = ~SER_CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: register image and error count
  logic [31:0] m_freq;
  logic [15:0] m_phase;
  logic [7:0]  m_amp;
  logic        m_en;
  int          m_errs;

  int n_cfg = 0;
  int n_err = 0;
  always @(negedge SER_CLK) begin
    if (CFG_UPDATE === 1'b1) n_cfg++;
    if (FRAME_ERR === 1'b1)  n_err++;
  end

  task automatic model_clear();
    m_freq = '0; m_phase = '0; m_amp = '0; m_en = 1'b0; m_errs = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge SER_CLK);
    RX_DV   = 1'b1;
    RX_BYTE = b;
    @(negedge SER_CLK);
    RX_DV   = 1'b0;
    RX_BYTE = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge SER_CLK);
  endtask

  // Sends one frame (gap < 0: random idle gaps) and checks its commit outcome
  task automatic send_frame(input string tag, input logic [7:0] a, input logic [31:0] d,
                            input logic [7:0] c, input int gap);
    logic [7:0] x;
    bit         good;
    send_byte(SYNC);
    idle(gap < 0 ? int'($urandom_range(0, 5)) : gap);
    send_byte(a);
    for (int i = 3; i >= 0; i--) begin
      idle(gap < 0 ? int'($urandom_range(0, 5)) : gap);
      send_byte(d[i*8 +: 8]);
    end
    idle(gap < 0 ? int'($urandom_range(0, 5)) : gap);
    send_byte(c);
    checks++;
    if (CFG_UPDATE !== 1'b0 || FRAME_ERR !== 1'b0) begin
      errors++;
      $display("FAIL %s early_pulse: cfg=%b err=%b required 0 0", tag, CFG_UPDATE, FRAME_ERR);
    end
    x    = a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    good = (c == x) && (a <= 8'h03);
    if (good) begin
      case (a)
        8'h00: m_freq  = d;
        8'h01: m_phase = d[15:0];
        8'h02: m_amp   = d[7:0];
        default: m_en  = d[0];
      endcase
    end else if (m_errs < 255) begin
      m_errs++;
    end
    @(posedge SER_CLK); #1;
    checks++;
    if (CFG_UPDATE !== good || FRAME_ERR !== !good) begin
      errors++;
      $display("FAIL %s pulse: cfg=%b err=%b required %b %b", tag, CFG_UPDATE, FRAME_ERR,
               good, !good);
    end
    checks++;
    if ({FREQ_WORD, PHASE_WORD, AMPLITUDE, OUT_EN, ERR_COUNT} !==
        {m_freq, m_phase, m_amp, m_en, 8'(m_errs)}) begin
      errors++;
      $display("FAIL %s regs: got %h %h %h %b %h required %h %h %h %b %h", tag, FREQ_WORD,
               PHASE_WORD, AMPLITUDE, OUT_EN, ERR_COUNT, m_freq, m_phase, m_amp, m_en,
               8'(m_errs));
    end
    @(posedge SER_CLK); #1;
    checks++;
    if (CFG_UPDATE !== 1'b0 || FRAME_ERR !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse_width: cfg=%b err=%b required 0 0", tag, CFG_UPDATE, FRAME_ERR);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; RX_DV = 1'b0; RX_BYTE = 8'h00;
    repeat (3) @(negedge SER_CLK);
    checks++;
    if ({FREQ_WORD, PHASE_WORD, AMPLITUDE, OUT_EN, CFG_UPDATE, FRAME_ERR, ERR_COUNT} !== '0) begin
      errors++;
      $display("FAIL reset_values: got %h %h %h %b %b %b %h required all 0", FREQ_WORD,
               PHASE_WORD, AMPLITUDE, OUT_EN, CFG_UPDATE, FRAME_ERR, ERR_COUNT);
    end
    RST = 1'b0;
    model_clear();
    idle(2);
  endtask

  task automatic test_directed();
    send_frame("freq_good",   8'h00, 32'h12345678, 8'h08, -1);
    send_frame("freq_badchk", 8'h00, 32'h12345678, 8'h09, -1);
    send_frame("amp_syncdata", 8'h02, 32'h0000A580, 8'h27, -1);
    send_frame("bad_addr",    8'h07, 32'h00000000, 8'h07, -1);
  endtask

  task automatic test_timeout();
    bit early = 0;
    int e0;
    send_byte(SYNC); idle(2);
    send_byte(8'h00); idle(3);
    send_byte(8'h12);
    e0 = n_err;
    for (int k = 1; k <= TMO; k++) begin
      @(posedge SER_CLK); #1;
      if (FRAME_ERR !== 1'b0) early = 1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL timeout_early: FRAME_ERR seen before %0d clocks, required none", TMO + 1);
    end
    @(posedge SER_CLK); #1;
    if (m_errs < 255) m_errs++;
    checks++;
    if (FRAME_ERR !== 1'b1 || ERR_COUNT !== 8'(m_errs)) begin
      errors++;
      $display("FAIL timeout_pulse: err=%b cnt=%h required 1 %h", FRAME_ERR, ERR_COUNT,
               8'(m_errs));
    end
    @(posedge SER_CLK); #1;
    checks++;
    if (FRAME_ERR !== 1'b0 || n_err != e0 + 1) begin
      errors++;
      $display("FAIL timeout_width: err=%b pulses=%0d required 0 1", FRAME_ERR, n_err - e0);
    end
    send_frame("after_timeout", 8'h03, 32'h00000001, 8'h02, -1);
  endtask

  task automatic test_byte_wins();
    // Every byte lands exactly on the last allowed gap cycle
    send_frame("byte_wins", 8'h01, 32'h00001234, 8'h27, TMO - 2);
  endtask

  task automatic test_hunt_noise();
    int e0;
    e0 = n_err;
    send_byte(8'h00); idle(1);
    send_byte(8'hFF); idle(2);
    send_byte(8'h5A); idle(1);
    send_frame("hunt_noise", 8'h01, 32'h0000BEEF, 8'h50, -1);
    checks++;
    if (n_err != e0) begin
      errors++;
      $display("FAIL noise_err: %0d error pulses, required 0", n_err - e0);
    end
  endtask

  task automatic test_random();
    logic [7:0]  a;
    logic [31:0] d;
    logic [7:0]  c;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [7:0] nb;
        nb = 8'($urandom);
        if (nb == SYNC) nb = 8'h00;
        send_byte(nb);
      end
      a = 8'($urandom_range(0, 5));
      d = $urandom;
      c = a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
      if ($urandom_range(0, 4) == 0) c = c ^ 8'($urandom_range(1, 255));
      send_frame("random", a, d, c, -1);
    end
  endtask

  task automatic test_reset_mid();
    int c0, e0;
    send_byte(SYNC); send_byte(8'h00); send_byte(8'h12);
    @(negedge SER_CLK);
    RST = 1'b1;
    #1;
    checks++;
    if ({FREQ_WORD, PHASE_WORD, AMPLITUDE, OUT_EN, CFG_UPDATE, FRAME_ERR, ERR_COUNT} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %h %h %h %b %b %b %h required all 0", FREQ_WORD,
               PHASE_WORD, AMPLITUDE, OUT_EN, CFG_UPDATE, FRAME_ERR, ERR_COUNT);
    end
    @(negedge SER_CLK);
    RST = 1'b0;
    model_clear();
    c0 = n_cfg; e0 = n_err;
    // Tail of the discarded frame must be hunted over silently
    send_byte(8'h34); send_byte(8'h56); send_byte(8'h78); send_byte(8'h08);
    idle(4);
    checks++;
    if (n_cfg != c0 || n_err != e0 || FREQ_WORD !== 32'h0 || ERR_COUNT !== 8'h00) begin
      errors++;
      $display("FAIL reset_hunt: cfg=%0d err=%0d freq=%h cnt=%h required 0 0 0 0",
               n_cfg - c0, n_err - e0, FREQ_WORD, ERR_COUNT);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] d;
    for (int n = 0; n < 300; n++) begin
      d = $urandom;
      send_frame("saturate", 8'h00, d, ~(d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0]), 0);
    end
    checks++;
    if (ERR_COUNT !== 8'hFF) begin
      errors++;
      $display("FAIL err_saturate: cnt=%h required ff", ERR_COUNT);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_byte_wins();
    test_hunt_noise();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cfg_ctrl.md
# uart_cfg_ctrl

Command-frame controller that sits between `uart_rx` and the DDS core. It consumes the received byte stream (`RX_DV`/`RX_BYTE`), delimits and validates fixed-length configuration frames, and commits their payload into the DDS control registers. A byte-gap timeout and checksum keep a corrupted or truncated frame from ever reaching the synthesizer. Frame errors are flagged and counted.

## Interface
- `F_CLK`, 12_000_000: `SER_CLK` frequency in Hz.
- `UART_BAUD`, 9600: line rate in baud; must match `uart_rx`.
- `TIMEOUT_CLKS`, `(F_CLK/UART_BAUD)*20`: maximum idle clocks between bytes inside a frame (two byte-times).
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `SER_CLK` in 1: sole clock; all logic on its rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `RX_DV` in 1: byte strobe from `uart_rx`. Each cycle it is high counts as one byte.
- `RX_BYTE` in 8: received byte; valid while `RX_DV` is high.
- `FREQ_WORD` out 32: DDS frequency tuning word.
- `PHASE_WORD` out 16: DDS phase offset.
- `AMPLITUDE` out 8: output amplitude scale.
- `OUT_EN` out 1: DDS output enable.
- `CFG_UPDATE` out 1: one-cycle pulse when any register is written.
- `FRAME_ERR` out 1: one-cycle pulse on a rejected frame.
- `ERR_COUNT` out 8: saturating count of rejected frames.

## Operation
- Frame format, 7 bytes: `SYNC_BYTE`, ADDR, D3, D2, D1, D0, CHK.
  - D3 is the most-significant byte of the 32-bit payload.
  - CHK = ADDR ^ D3 ^ D2 ^ D1 ^ D0.
- Register map:
  - ADDR 0x00: `FREQ_WORD` = payload[31:0].
  - ADDR 0x01: `PHASE_WORD` = payload[15:0].
  - ADDR 0x02: `AMPLITUDE` = payload[7:0].
  - ADDR 0x03: `OUT_EN` = payload[0].
  - Any other ADDR: frame rejected.
  - Unused payload bits are ignored.
- States: HUNT, ADDR, DATA, CHECK, COMMIT.
  - HUNT: a byte equal to `SYNC_BYTE` -> ADDR. Any other byte is dropped silently and is not an error.
  - ADDR: latch ADDR, seed the running XOR with it, clear the byte index -> DATA.
  - DATA: shift each byte into the payload and XOR it into the checksum; after the 4th byte -> CHECK. A `SYNC_BYTE` value here is ordinary data; there is no resync.
  - CHECK: compare the byte with the running XOR and record the match flag -> COMMIT.
  - COMMIT: lasts one cycle, then -> HUNT unconditionally.
    - If the checksum matched and ADDR <= 0x03, write the target register and pulse `CFG_UPDATE`.
    - Otherwise pulse `FRAME_ERR` and increment `ERR_COUNT`; no register changes.
- Timeout:
  - A 32-bit gap counter clears on every accepted byte and increments in ADDR, DATA and CHECK.
  - When it reaches `TIMEOUT_CLKS-1` without a byte: -> HUNT, pulse `FRAME_ERR`, increment `ERR_COUNT`; the partial frame is discarded.
  - The counter is held at 0 in HUNT and COMMIT.
- If `RX_DV` arrives in the same cycle the counter reaches its limit, the byte wins: it is accepted, the counter clears, and no timeout occurs.
- `RX_DV` arriving during COMMIT is dropped, which is safe because `uart_rx` spaces bytes by at least one bit-time.
- `ERR_COUNT` saturates at 8'hFF; a further error still pulses `FRAME_ERR`.
- `CFG_UPDATE` and `FRAME_ERR` are never high in the same cycle.

## Timing
- Reset values: state HUNT; `FREQ_WORD`, `PHASE_WORD`, `AMPLITUDE`, `OUT_EN`, `ERR_COUNT`, gap counter, payload and checksum all 0; `CFG_UPDATE` 0; `FRAME_ERR` 0.
- Asserting `RST` mid-frame discards the partial frame. It does not count as an error.
- Commit latency:
  - CHK byte is sampled with `RX_DV` at edge E; the state is COMMIT during the E..E+1 cycle.
  - At edge E+1 the new register value and `CFG_UPDATE`=1 (or `FRAME_ERR`=1) appear.
  - Both pulses deassert at edge E+2.
- Timeout timing: the last byte is accepted at edge E; if no byte arrives, `FRAME_ERR` appears at edge E+`TIMEOUT_CLKS`+1 and lasts one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Good frequency frame: A5 00 12 34 56 78 08 -> `FREQ_WORD`=0x12345678 one cycle after the CHK strobe; `CFG_UPDATE` high for exactly 1 cycle; `ERR_COUNT`=0.
- Bad checksum: A5 00 12 34 56 78 09 -> `FREQ_WORD` unchanged; `FRAME_ERR` high for 1 cycle; `ERR_COUNT`=1.
- Amplitude and sync-in-data: A5 02 00 00 A5 80 27 -> `AMPLITUDE`=0x80; bad ADDR A5 07 00 00 00 00 07 -> `FRAME_ERR`, no register change.
- Timeout: A5 00 12 then silence -> `FRAME_ERR` after `TIMEOUT_CLKS`+1 clocks; a following good frame A5 03 00 00 00 01 02 -> `OUT_EN`=1.
- Hunt and noise: bytes 00 FF 5A before A5 01 00 00 BE EF 50 -> no error; `PHASE_WORD`=0xBEEF.
- Reset mid-frame: `RST` pulsed after A5 00 12 -> all outputs 0, state HUNT; 300 error frames -> `ERR_COUNT` holds 0xFF.
